nibble_alu_sequencer: RTL
=========================

NIBBLE_ALU_SEQUENCER -- requirements
Module: nibble_alu_sequencer

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the number of 4-bit slices per operation; the operand width is W = 4*NIBBLES.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-005 The block SHALL have ports a_in and b_in, input, W bits each: operands, captured on an accepted start.
REQ-006 The block SHALL have port s_in, input, 4 bits: ALU function select, captured on an accepted start.
REQ-007 The block SHALL have port m_in, input, 1 bit: ALU mode, captured on an accepted start.
REQ-008 The block SHALL have port cin, input, 1 bit: carry into nibble 0, captured on an accepted start.
REQ-009 The block SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-010 The block SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-011 The block SHALL have port result, output, W bits: assembled result.
REQ-012 The block SHALL have port cout, output, 1 bit: Pout of the last nibble.
REQ-013 The block SHALL have port zero, output, 1 bit: high when result == 0.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 In IDLE, start=1 at a rising edge SHALL latch a_in, b_in, s_in, m_in and cin, clear the nibble counter, and enter RUN.
REQ-016 In RUN with counter k, the ALU SHALL receive A nibble k, B nibble k, the latched S/M, and Pin = the carry register (latched cin when k=0).
REQ-017 At each RUN edge, result[4k+3:4k] SHALL take the ALU R output, the carry register SHALL take Pout, and k SHALL increment.
REQ-018 When k = NIBBLES-1 at a RUN edge, the FSM SHALL enter DONE; RUN therefore lasts exactly NIBBLES cycles.
REQ-019 DONE SHALL last one cycle with done=1, then return to IDLE unconditionally.
REQ-020 done SHALL first be high NIBBLES+1 cycles after the edge that sampled start.
REQ-021 cout and zero SHALL be registered and valid when done is high.
REQ-022 result, cout and zero SHALL hold their values until the next accepted start; result nibbles not yet computed MAY be intermediate while busy=1.
REQ-023 start SHALL be ignored while busy=1; a request is never queued.
REQ-024 Changes on a_in, b_in, s_in, m_in or cin after acceptance SHALL NOT affect the operation in progress.
REQ-025 The carry SHALL chain identically in logic mode (M); result bits depend only on the ALU's own function table.
REQ-026 The counter SHALL be ceil(log2(NIBBLES)) bits wide, minimum 1 bit, and SHALL never wrap while in RUN.

Reset
REQ-027 rst_n=0 at a rising edge SHALL force the FSM to IDLE and clear the counter, carry register, result, cout, zero, busy and done to 0, in any state including mid-RUN.
REQ-028 A start asserted in the same cycle as rst_n=0 SHALL be discarded.

Structure
REQ-029 The FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL be defined in shared package alu_ctrl_pkg, together with the NIBBLES default.
REQ-030 The block SHALL instantiate exactly one parallel_ALU as its only sub-module, time-shared across nibbles.
REQ-031 Operand nibble selection SHALL be a counter-indexed mux or a right-shift of the latched operands (implementer's choice); no combinational path from start to any output.

Verification
REQ-032 Add code, A=0xFFFF, B=0x0001, cin per add convention -> done at cycle 5; result=0x0000, cout=1, zero=1.
REQ-033 Add code, A=0x1234, B=0x0FFF -> result=0x2233, cout=0, zero=0; busy high exactly 5 cycles.
REQ-034 Random S/M/A/B/cin, 1000 operations -> result and cout match a golden model of NIBBLES parallel_ALU instances chained combinationally, Pout to Pin.
REQ-035 start pulsed in every RUN and DONE cycle -> no extra operation; exactly one done per accepted start.
REQ-036 rst_n low during the 2nd RUN cycle -> next cycle IDLE, all outputs 0; a subsequent start completes correctly.
REQ-037 Back-to-back: start held high continuously -> one operation accepted per NIBBLES+2 cycles, each done a single cycle wide.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer: FSM encoding,
// default slice count and the add function code.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLES_DEFAULT = 4;

  // M=0 with this select gives R = A + B + Pin
  localparam logic [3:0] S_ADD = 4'b1001;

endpackage

// File: rtl/parallel_alu.sv
// 4-bit ALU slice with an active-high carry chain. Pout always comes from the
// arithmetic sum, so the carry ripples the same way in logic mode.
module parallel_ALU (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       pin,
  output logic [3:0] r,
  output logic       pout
);

  logic [3:0] x;
  logic [3:0] y;
  logic [4:0] sum;

  // arithmetic operand pair, then R = X + Y + Pin; "minus one" uses Y = 4'hF
  always_comb begin
    x = a;
    y = 4'h0;
    case (s)
      4'd0:    begin x = a;        y = 4'h0;     end
      4'd1:    begin x = a | b;    y = 4'h0;     end
      4'd2:    begin x = a | ~b;   y = 4'h0;     end
      4'd3:    begin x = 4'h0;     y = 4'hF;     end
      4'd4:    begin x = a;        y = a & ~b;   end
      4'd5:    begin x = a | b;    y = a & ~b;   end
      4'd6:    begin x = a;        y = ~b;       end
      4'd7:    begin x = a & ~b;   y = 4'hF;     end
      4'd8:    begin x = a;        y = a & b;    end
      4'd9:    begin x = a;        y = b;        end
      4'd10:   begin x = a | ~b;   y = a & b;    end
      4'd11:   begin x = a & b;    y = 4'hF;     end
      4'd12:   begin x = a;        y = a;        end
      4'd13:   begin x = a | b;    y = a;        end
      4'd14:   begin x = a | ~b;   y = a;        end
      4'd15:   begin x = a;        y = 4'hF;     end
      default: begin x = a;        y = 4'h0;     end
    endcase
    sum  = {1'b0, x} + {1'b0, y} + {4'h0, pin};
    pout = sum[4];
  end

  // logic-mode function table, otherwise the arithmetic sum
  always_comb begin
    r = sum[3:0];
    if (m) begin
      case (s)
        4'd0:    r = ~a;
        4'd1:    r = ~(a | b);
        4'd2:    r = ~a & b;
        4'd3:    r = 4'h0;
        4'd4:    r = ~(a & b);
        4'd5:    r = ~b;
        4'd6:    r = a ^ b;
        4'd7:    r = a & ~b;
        4'd8:    r = ~a | b;
        4'd9:    r = ~(a ^ b);
        4'd10:   r = b;
        4'd11:   r = a & b;
        4'd12:   r = 4'hF;
        4'd13:   r = a | ~b;
        4'd14:   r = a | b;
        4'd15:   r = a;
        default: r = a;
      endcase
    end else begin
      r = sum[3:0];
    end
  end

endmodule

// File: rtl/nibble_alu_sequencer.sv
// Runs a W-bit ALU operation through one shared 4-bit slice, one nibble per
// clock, chaining the slice carry through a register.
module nibble_alu_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a_in,
  input  logic [4*NIBBLES-1:0] b_in,
  input  logic [3:0]           s_in,
  input  logic                 m_in,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout,
  output logic                 zero
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_t        state;
  state_t        state_nxt;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [3:0]    s_q;
  logic          m_q;
  logic          carry;
  logic [CW-1:0] cnt;
  logic [W-1:0]  result_nxt;
  logic [3:0]    alu_r;
  logic          alu_pout;

  // operands shift right each RUN cycle, so the slice always sees bits [3:0]
  parallel_ALU u_alu (
    .a    (a_q[3:0]),
    .b    (b_q[3:0]),
    .s    (s_q),
    .m    (m_q),
    .pin  (carry),
    .r    (alu_r),
    .pout (alu_pout)
  );

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
        else       state_nxt = IDLE;
      end
      RUN: begin
        if (cnt == LAST) state_nxt = DONE;
        else             state_nxt = RUN;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // current result with this cycle's slice output merged into nibble k
  always_comb begin
    result_nxt = result;
    result_nxt[int'(cnt) * 4 +: 4] = alu_r;
  end

  // state, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      s_q    <= 4'h0;
      m_q    <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
      zero   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a_in;
            b_q   <= b_in;
            s_q   <= s_in;
            m_q   <= m_in;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_q    <= a_q >> 4;
          b_q    <= b_q >> 4;
          carry  <= alu_pout;
          result <= result_nxt;
          // counter parks on the last slice instead of wrapping
          if (cnt == LAST) begin
            cout <= alu_pout;
            zero <= (result_nxt == '0);
          end else begin
            cnt  <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
